input_setup: RTL and testbench
==============================

Name: input_setup

Overview:
- Sits directly downstream of the unified buffer, between it and the 2x2 systolic array.
- Captures one 2x2 activation tile (four 32-bit words), holds it, then streams it into the two array rows with a one-cycle diagonal skew.
- Zero-pads the skew bubbles and flags each valid word.
- Supports stall (backpressure) and signals tile completion to the controller.

Parameters:
DATA_W, 32, width of each activation word.
CNT_W, 8, width of the streamed-tile counter.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
load  input  1  capture in_00..in_11 this cycle (when load_ready=1)
in_00  input  DATA_W  tile word row0 col0
in_01  input  DATA_W  tile word row0 col1
in_10  input  DATA_W  tile word row1 col0
in_11  input  DATA_W  tile word row1 col1
start  input  1  begin streaming the held tile
stall  input  1  freeze streaming this cycle
load_ready  output  1  1 in IDLE or READY
a_row0  output  DATA_W  activation into array row 0
a_row1  output  DATA_W  activation into array row 1
valid_row0  output  1  a_row0 carries a tile word
valid_row1  output  1  a_row1 carries a tile word
busy  output  1  1 while in STREAM
done  output  1  one-cycle pulse after last word leaves
tile_count  output  CNT_W  number of tiles fully streamed

Behaviour:
- Reset (async, asserted any time including mid-STREAM):
  - state=IDLE, step=0, tile registers=0.
  - a_row0=a_row1=0, valid_row0=valid_row1=0, busy=0, done=0, tile_count=0.
  - A tile partially streamed is discarded; no done pulse.
- States: IDLE (no tile), READY (tile held), STREAM (step 0..2).
- IDLE:
  - load=1 -> capture the four words, go to READY.
  - start is ignored.
- READY:
  - load=1 -> overwrite the tile, stay READY; load takes priority over a simultaneous start, which is ignored.
  - start=1 with load=0 -> go to STREAM, step=0.
- STREAM:
  - load is ignored (load_ready=0).
  - Outputs are registered. The edge that enters STREAM also drives the step-0 outputs.
  - step 0: a_row0=in_00, v0=1; a_row1=0, v1=0.
  - step 1: a_row0=in_01, v0=1; a_row1=in_10, v1=1.
  - step 2: a_row0=0, v0=0; a_row1=in_11, v1=1.
  - At the edge ending step 2: state=IDLE; outputs -> 0 / valid 0; done=1 for exactly one cycle; tile_count += 1, wrapping modulo 2^CNT_W.
  - Latency: the first valid word appears on the cycle after start is sampled. done appears 3 cycles after the first valid word, or later if stalled.
- stall=1 in STREAM:
  - step, outputs and valids hold their current values. No advance, no done.
  - Valids stay asserted; the array must also be stalled.
- stall in IDLE/READY has no effect. A stall arriving on the final edge delays done.
- Back-to-back tiles:
  - load is accepted in the done cycle (state is already IDLE).
  - Minimum tile period = 5 cycles: load, start, then 3 stream cycles.
- busy=1 exactly while state=STREAM.
- Held tile values never change during STREAM.

Test Plan:
- Reset, then load with 11,12,21,22, then start -> cycle+1: row0=11/v0=1, row1=0/v1=0. cycle+2: 12/1, 21/1. cycle+3: 0/0, 22/1. cycle+4: done=1, busy=0, tile_count=1.
- start in IDLE with no tile -> no state change, valids stay 0, busy=0, done=0.
- Load 1,2,3,4, then load 5,6,7,8 with start asserted in the same cycle -> stays READY. A later start streams 5,6,7,8.
- Stall held 2 cycles during step 1 -> outputs frozen at 12/21 with both valids 1 for 3 cycles total. done arrives 2 cycles late, tile_count increments once.
- Assert reset during step 1 -> all outputs 0 immediately (asynchronous), state IDLE, no done, tile_count=0.
- 256 back-to-back tiles with load in each done cycle -> tile_count wraps to 0. load during STREAM ignored; load_ready=0 throughout STREAM.

Source files
------------

// File: rtl/input_setup.sv
// Activation tile staging between the unified buffer and a 2x2 systolic array:
// captures one 2x2 tile, then streams it into the two array rows with a one-cycle diagonal skew.
module input_setup #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] in_00,
    input  logic [DATA_W-1:0] in_01,
    input  logic [DATA_W-1:0] in_10,
    input  logic [DATA_W-1:0] in_11,
    input  logic              start,
    input  logic              stall,
    output logic              load_ready,
    output logic [DATA_W-1:0] a_row0,
    output logic [DATA_W-1:0] a_row1,
    output logic              valid_row0,
    output logic              valid_row1,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  tile_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READY  = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t             r_state;
    logic [1:0]         r_step;
    logic [DATA_W-1:0]  r_t00;
    logic [DATA_W-1:0]  r_t01;
    logic [DATA_W-1:0]  r_t10;
    logic [DATA_W-1:0]  r_t11;
    logic [DATA_W-1:0]  r_a_row0;
    logic [DATA_W-1:0]  r_a_row1;
    logic               r_valid_row0;
    logic               r_valid_row1;
    logic               r_busy;
    logic               r_done;
    logic               r_load_ready;
    logic [CNT_W-1:0]   r_tile_count;

    // Tile hold + skewed streaming FSM; every output is driven from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_step       <= 2'd0;
            r_t00        <= '0;
            r_t01        <= '0;
            r_t10        <= '0;
            r_t11        <= '0;
            r_a_row0     <= '0;
            r_a_row1     <= '0;
            r_valid_row0 <= 1'b0;
            r_valid_row1 <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_load_ready <= 1'b1;
            r_tile_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_t00   <= in_00;
                        r_t01   <= in_01;
                        r_t10   <= in_10;
                        r_t11   <= in_11;
                        r_state <= S_READY;
                    end
                end

                S_READY: begin
                    // A new tile wins over a simultaneous start.
                    if (load) begin
                        r_t00 <= in_00;
                        r_t01 <= in_01;
                        r_t10 <= in_10;
                        r_t11 <= in_11;
                    end else if (start) begin
                        r_state      <= S_STREAM;
                        r_step       <= 2'd0;
                        r_a_row0     <= r_t00;
                        r_valid_row0 <= 1'b1;
                        r_a_row1     <= '0;
                        r_valid_row1 <= 1'b0;
                        r_busy       <= 1'b1;
                        r_load_ready <= 1'b0;
                    end
                end

                S_STREAM: begin
                    if (!stall) begin
                        case (r_step)
                            2'd0: begin
                                r_step       <= 2'd1;
                                r_a_row0     <= r_t01;
                                r_valid_row0 <= 1'b1;
                                r_a_row1     <= r_t10;
                                r_valid_row1 <= 1'b1;
                            end
                            2'd1: begin
                                r_step       <= 2'd2;
                                r_a_row0     <= '0;
                                r_valid_row0 <= 1'b0;
                                r_a_row1     <= r_t11;
                                r_valid_row1 <= 1'b1;
                            end
                            default: begin
                                // Last word has left: release the array and report completion.
                                r_state      <= S_IDLE;
                                r_step       <= 2'd0;
                                r_a_row0     <= '0;
                                r_valid_row0 <= 1'b0;
                                r_a_row1     <= '0;
                                r_valid_row1 <= 1'b0;
                                r_busy       <= 1'b0;
                                r_done       <= 1'b1;
                                r_load_ready <= 1'b1;
                                r_tile_count <= r_tile_count + CNT_W'(1);
                            end
                        endcase
                    end
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_step       <= 2'd0;
                    r_busy       <= 1'b0;
                    r_load_ready <= 1'b1;
                end
            endcase
        end
    end

    assign load_ready = r_load_ready;
    assign a_row0     = r_a_row0;
    assign a_row1     = r_a_row1;
    assign valid_row0 = r_valid_row0;
    assign valid_row1 = r_valid_row1;
    assign busy       = r_busy;
    assign done       = r_done;
    assign tile_count = r_tile_count;

endmodule

// File: tb/tb_input_setup.sv
// Self-checking bench for input_setup: directed scenarios plus random traffic,
// all compared every cycle against a skew-formula reference model.
module tb_input_setup;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;

    logic              clk;
    logic              reset;
    logic              load;
    logic [DATA_W-1:0] in_00;
    logic [DATA_W-1:0] in_01;
    logic [DATA_W-1:0] in_10;
    logic [DATA_W-1:0] in_11;
    logic              start;
    logic              stall;
    logic              load_ready;
    logic [DATA_W-1:0] a_row0;
    logic [DATA_W-1:0] a_row1;
    logic              valid_row0;
    logic              valid_row1;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  tile_count;

    input_setup #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .in_00      (in_00),
        .in_01      (in_01),
        .in_10      (in_10),
        .in_11      (in_11),
        .start      (start),
        .stall      (stall),
        .load_ready (load_ready),
        .a_row0     (a_row0),
        .a_row1     (a_row1),
        .valid_row0 (valid_row0),
        .valid_row1 (valid_row1),
        .busy       (busy),
        .done       (done),
        .tile_count (tile_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: 0 = no tile, 1 = tile held, 2 = streaming at skew position m_pos.
    int          m_mode;
    int          m_pos;
    logic [31:0] m_tile [2][2];
    int          m_done;
    int          m_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pos   = 0;
        m_done  = 0;
        m_count = 0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                m_tile[r][c] = '0;
    endtask

    task automatic model_edge(input logic l, input logic s, input logic st,
                              input logic [31:0] w00, input logic [31:0] w01,
                              input logic [31:0] w10, input logic [31:0] w11);
        m_done = 0;
        if (m_mode == 2) begin
            if (!st) begin
                if (m_pos == 2) begin
                    m_mode  = 0;
                    m_done  = 1;
                    m_count = (m_count + 1) % 256;
                end else begin
                    m_pos++;
                end
            end
        end else if (l) begin
            m_tile[0][0] = w00; m_tile[0][1] = w01;
            m_tile[1][0] = w10; m_tile[1][1] = w11;
            m_mode = 1;
        end else if (s && m_mode == 1) begin
            m_mode = 2;
            m_pos  = 0;
        end
    endtask

    // Row r at skew position p carries tile column p-r when that column exists.
    task automatic check_all();
        logic [31:0] ea [2];
        logic        ev [2];
        for (int r = 0; r < 2; r++) begin
            int col;
            col   = m_pos - r;
            ev[r] = 1'b0;
            ea[r] = '0;
            if (m_mode == 2 && col >= 0 && col <= 1) begin
                ev[r] = 1'b1;
                ea[r] = m_tile[r][col];
            end
        end
        chk("a_row0",     64'(a_row0),     64'(ea[0]));
        chk("valid_row0", 64'(valid_row0), 64'(ev[0]));
        chk("a_row1",     64'(a_row1),     64'(ea[1]));
        chk("valid_row1", 64'(valid_row1), 64'(ev[1]));
        chk("busy",       64'(busy),       64'(m_mode == 2));
        chk("load_ready", 64'(load_ready), 64'(m_mode != 2));
        chk("done",       64'(done),       64'(m_done));
        chk("tile_count", 64'(tile_count), 64'(m_count));
    endtask

    task automatic cyc(input logic l, input logic s, input logic st,
                       input logic [31:0] w00, input logic [31:0] w01,
                       input logic [31:0] w10, input logic [31:0] w11);
        @(negedge clk);
        load  = l;
        start = s;
        stall = st;
        in_00 = w00; in_01 = w01; in_10 = w10; in_11 = w11;
        @(posedge clk);
        model_edge(l, s, st, w00, w01, w10, w11);
        #1;
        check_all();
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        in_00 = '0; in_01 = '0; in_10 = '0; in_11 = '0;
        model_reset();
        #12;
        check_all();
        chk("reset_load_ready", 64'(load_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;

        // Basic tile with literal expectations.
        cyc(1'b1, 1'b0, 1'b0, 32'd11, 32'd12, 32'd21, 32'd22);
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("lit_s0_row0", 64'({valid_row0, a_row0}), 64'({1'b1, 32'd11}));
        chk("lit_s0_row1", 64'({valid_row1, a_row1}), 64'({1'b0, 32'd0}));
        idle_cyc();
        chk("lit_s1_row0", 64'({valid_row0, a_row0}), 64'({1'b1, 32'd12}));
        chk("lit_s1_row1", 64'({valid_row1, a_row1}), 64'({1'b1, 32'd21}));
        idle_cyc();
        chk("lit_s2_row0", 64'({valid_row0, a_row0}), 64'({1'b0, 32'd0}));
        chk("lit_s2_row1", 64'({valid_row1, a_row1}), 64'({1'b1, 32'd22}));
        idle_cyc();
        chk("lit_done", 64'({done, busy, tile_count}), 64'({1'b1, 1'b0, 8'd1}));
        idle_cyc();
        chk("lit_done_pulse", 64'(done), 64'd0);

        // Start with no tile held is ignored.
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("lit_idle_start", 64'({busy, valid_row0, valid_row1, done}), 64'd0);

        // Overwrite with simultaneous start: load wins.
        cyc(1'b1, 1'b0, 1'b0, 32'd1, 32'd2, 32'd3, 32'd4);
        cyc(1'b1, 1'b1, 1'b0, 32'd5, 32'd6, 32'd7, 32'd8);
        chk("lit_overwrite_busy", 64'({busy, load_ready}), 64'({1'b0, 1'b1}));
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("lit_overwrite_s0", 64'(a_row0), 64'd5);
        idle_cyc();
        chk("lit_overwrite_s1", 64'({a_row0, a_row1}), 64'({32'd6, 32'd7}));
        idle_cyc();
        chk("lit_overwrite_s2", 64'(a_row1), 64'd8);
        idle_cyc();

        // Stall for two cycles during step 1.
        cyc(1'b1, 1'b0, 1'b0, 32'd11, 32'd12, 32'd21, 32'd22);
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        idle_cyc();
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
            chk("lit_stall_hold", 64'({valid_row0, a_row0, valid_row1, a_row1}) & 64'hFFFF_FFFF_FFFF_FFFF,
                64'({1'b1, 32'd12, 1'b1, 32'd21}) & 64'hFFFF_FFFF_FFFF_FFFF);
            chk("lit_stall_nodone", 64'(done), 64'd0);
        end
        idle_cyc();
        idle_cyc();
        chk("lit_stall_done", 64'({done, tile_count}), 64'({1'b1, 8'd3}));

        // Asynchronous reset during step 1.
        cyc(1'b1, 1'b0, 1'b0, 32'hA, 32'hB, 32'hC, 32'hD);
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        idle_cyc();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("lit_async_rst", 64'({a_row0, valid_row0, valid_row1, busy, done, tile_count}), 64'd0);
        chk("lit_async_rst_a1", 64'(a_row1), 64'd0);
        check_all();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) idle_cyc();

        // 256 back-to-back tiles, with ignored loads during streaming.
        for (int t = 0; t < 256; t++) begin
            cyc(1'b1, 1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom);
            cyc(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
            for (int k = 0; k < 3; k++)
                cyc(1'b1, 1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom);
            if (t == 0) chk("lit_b2b_first", 64'(tile_count), 64'd1);
        end
        chk("lit_b2b_wrap", 64'({done, tile_count}), 64'({1'b1, 8'd0}));

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 4) == 0,
                $urandom, $urandom, $urandom, $urandom);
            if (($urandom % 600) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
